rvc_fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32IC pipeline; sits directly upstream of the RVC instruction cache.

---
 rtl/rvc_fetch_pkg.sv | 20 ++
 rtl/rvc_fetch_stage_perf.sv | 25 ++
 rtl/rvc_fetch_stage.sv | 105 ++++++++++
 tb/tb_rvc_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_fetch_pkg.sv
// Shared constants, state type and byte-order helper for the RV32IC fetch stage.
package rvc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] INC_RVC       = 32'd2;
  localparam logic [31:0] INC_32        = 32'd4;
  localparam logic [31:0] PC_MASK       = 32'hFFFF_FFFE;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  // The cache returns memory byte order; the decoder wants natural order.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rvc_fetch_stage_perf.sv
// Fetch performance counters; only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        proc_reset,
  input  logic        fetch_evt,
  input  logic        rvc_evt,
  input  logic        stall_evt,
  output logic [31:0] fetch_cnt,
  output logic [31:0] rvc_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      fetch_cnt <= '0;
      rvc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_evt) fetch_cnt <= fetch_cnt + 32'd1;
      if (rvc_evt)   rvc_cnt   <= rvc_cnt + 32'd1;
      if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/rvc_fetch_stage.sv
// IF stage of the RV32IC pipeline: owns the PC, drives the RVC cache, fills IF/ID.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module rvc_fetch_stage
  import rvc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        proc_reset,
  output logic        proc_read,
  output logic [30:0] proc_addr,
  input  logic [31:0] proc_rdata,
  input  logic        proc_stall,
  input  logic        proc_pcadd,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_inc,
  output logic        ifid_is_rvc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_rvc_cnt,
  output logic [31:0] perf_stall_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pending_target;
  logic [31:0]  target_even;
  logic [31:0]  pc_seq;

  assign target_even = branch_target & PC_MASK;
  assign pc_seq      = pc + (proc_pcadd ? INC_32 : INC_RVC);
  assign proc_addr   = pc[31:1];

  // A redirect that arrives during a miss is parked in PEND so proc_addr
  // stays frozen until the cache finishes its refill.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state          <= RUN;
      pc             <= RESET_PC & PC_MASK;
      pending_target <= '0;
      proc_read      <= 1'b0;
      ifid_valid     <= 1'b0;
      ifid_instr     <= NOP_INSTR;
      ifid_pc        <= '0;
      ifid_pc_inc    <= '0;
      ifid_is_rvc    <= 1'b0;
    end else begin
      proc_read <= 1'b1;
      if (state == PEND) begin
        ifid_valid <= 1'b0;
        if (proc_stall) begin
          if (branch_taken) pending_target <= target_even;
        end else begin
          pc    <= branch_taken ? target_even : pending_target;
          state <= RUN;
        end
      end else if (branch_taken && proc_stall) begin
        state          <= PEND;
        pending_target <= target_even;
        ifid_valid     <= 1'b0;
      end else if (branch_taken) begin
        pc         <= target_even;
        ifid_valid <= 1'b0;
      end else if (!id_stall) begin
        if (proc_stall) begin
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_INSTR;
        end else begin
          ifid_valid  <= 1'b1;
          ifid_instr  <= byte_swap(proc_rdata);
          ifid_pc     <= pc;
          ifid_pc_inc <= pc_seq;
          ifid_is_rvc <= ~proc_pcadd;
          pc          <= pc_seq;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic deliver;
  assign deliver = (state == RUN) && !branch_taken && !id_stall && !proc_stall;

  fetch_perf_counters u_perf (
    .clk        (clk),
    .proc_reset (proc_reset),
    .fetch_evt  (deliver),
    .rvc_evt    (deliver && !proc_pcadd),
    .stall_evt  (proc_stall),
    .fetch_cnt  (perf_fetch_cnt),
    .rvc_cnt    (perf_rvc_cnt),
    .stall_cnt  (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_rvc_cnt   = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rvc_fetch_stage.sv
// Scoreboard bench for rvc_fetch_stage: directed scenarios plus randomized traffic
// checked against a rule-level model of the fetch stage.
module tb_rvc_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        proc_reset;
  logic        proc_read;
  logic [30:0] proc_addr;
  logic [31:0] proc_rdata;
  logic        proc_stall;
  logic        proc_pcadd;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_inc;
  logic        ifid_is_rvc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_rvc_cnt;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  rvc_fetch_stage dut (
    .clk            (clk),
    .proc_reset     (proc_reset),
    .proc_read      (proc_read),
    .proc_addr      (proc_addr),
    .proc_rdata     (proc_rdata),
    .proc_stall     (proc_stall),
    .proc_pcadd     (proc_pcadd),
    .id_stall       (id_stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_inc    (ifid_pc_inc),
    .ifid_is_rvc    (ifid_is_rvc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_rvc_cnt   (perf_rvc_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  typedef struct {
    logic [31:0] read, addr, valid, instr, ipc, inc, rvc, fcnt, rcnt, scnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference state: byte PC, parked redirect, and the IF/ID contents.
  bit [31:0] m_pc, m_tgt, m_instr, m_ipc, m_inc, m_fcnt, m_rcnt, m_scnt;
  bit        m_redir, m_valid, m_rvc, m_read;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0; m_tgt = 32'h0; m_redir = 1'b0; m_read = 1'b0;
    m_valid = 1'b0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_inc = 32'h0; m_rvc = 1'b0;
    m_fcnt = 32'h0; m_rcnt = 32'h0; m_scnt = 32'h0;
  endtask

  task automatic modelStep(input bit pcadd, input bit [31:0] rdata, input bit stl,
                           input bit ids, input bit br, input bit [31:0] tgt);
    bit [31:0] even;
    even = tgt - (tgt % 2);
    m_read = 1'b1;
    if (stl) m_scnt = m_scnt + 1;
    if (m_redir || br) begin
      // Any redirect activity leaves the IF/ID slot holding nothing useful.
      m_valid = 1'b0;
      if (br) m_tgt = even;
      if (stl) m_redir = 1'b1;
      else begin
        m_pc = m_tgt;
        m_redir = 1'b0;
      end
    end else if (!ids) begin
      if (stl) begin
        m_valid = 1'b0;
        m_instr = 32'h0000_0013;
      end else begin
        for (int k = 0; k < 4; k++) m_instr[8*k +: 8] = rdata[8*(3-k) +: 8];
        m_valid = 1'b1;
        m_ipc   = m_pc;
        m_inc   = m_pc + (pcadd ? 32'd4 : 32'd2);
        m_pc    = m_inc;
        m_rvc   = !pcadd;
        m_fcnt  = m_fcnt + 1;
        if (!pcadd) m_rcnt = m_rcnt + 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit pcadd, input bit [31:0] rdata, input bit stl,
                               input bit ids, input bit br, input bit [31:0] tgt);
    exp_t e;
    @(negedge clk);
    proc_pcadd = pcadd; proc_rdata = rdata; proc_stall = stl;
    id_stall = ids; branch_taken = br; branch_target = tgt;
    modelStep(pcadd, rdata, stl, ids, br, tgt);
    e.read = {31'h0, m_read};   e.addr = m_pc >> 1;   e.valid = {31'h0, m_valid};
    e.instr = m_instr;          e.ipc = m_ipc;        e.inc = m_inc;
    e.rvc = {31'h0, m_rvc};
    e.fcnt = PERF ? m_fcnt : 32'h0;
    e.rcnt = PERF ? m_rcnt : 32'h0;
    e.scnt = PERF ? m_scnt : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hit(input bit pcadd, input bit [31:0] rdata);
    applyStimulus(pcadd, rdata, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    proc_reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_read",  {31'h0, proc_read},  32'h0);
    checkOutput("rst_addr",  {1'b0, proc_addr},   32'h0);
    checkOutput("rst_valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("rst_instr", ifid_instr,          32'h0000_0013);
    checkOutput("rst_pc",    ifid_pc,             32'h0);
    checkOutput("rst_inc",   ifid_pc_inc,         32'h0);
    checkOutput("rst_rvc",   {31'h0, ifid_is_rvc}, 32'h0);
    checkOutput("rst_scnt",  perf_stall_cnt,      32'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    proc_reset = 1'b0;
  endtask

  // Monitor: compares every post-edge output set against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (!proc_reset && sb.size() != 0) begin
      mon_e = sb.pop_front();
      checkOutput("read",  {31'h0, proc_read},   mon_e.read);
      checkOutput("addr",  {1'b0, proc_addr},    mon_e.addr);
      checkOutput("valid", {31'h0, ifid_valid},  mon_e.valid);
      checkOutput("instr", ifid_instr,           mon_e.instr);
      checkOutput("pc",    ifid_pc,              mon_e.ipc);
      checkOutput("inc",   ifid_pc_inc,          mon_e.inc);
      checkOutput("rvc",   {31'h0, ifid_is_rvc}, mon_e.rvc);
      checkOutput("fcnt",  perf_fetch_cnt,       mon_e.fcnt);
      checkOutput("rcnt",  perf_rvc_cnt,         mon_e.rcnt);
      checkOutput("scnt",  perf_stall_cnt,       mon_e.scnt);
    end
  end

  initial begin
    logic [31:0] hold_pc, hold_instr, hold_scnt;
    logic [30:0] hold_addr;
    proc_rdata = 32'h0; proc_stall = 1'b0; proc_pcadd = 1'b0;
    id_stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    doReset();

    // Sequential hits with mixed lengths.
    hit(1'b1, 32'h1300_0000);
    checkOutput("swap_instr", ifid_instr, 32'h0000_0013);
    checkOutput("first_rvc", {31'h0, ifid_is_rvc}, 32'h0);
    hit(1'b1, 32'h1300_0000);
    hit(1'b0, 32'h1300_0000);
    checkOutput("third_rvc", {31'h0, ifid_is_rvc}, 32'h1);
    checkOutput("third_pc", ifid_pc, 32'h8);
    hit(1'b1, 32'h1300_0000);
    checkOutput("fourth_pc", ifid_pc, 32'hA);
    checkOutput("fourth_inc", ifid_pc_inc, 32'hE);
    checkOutput("fourth_addr", {1'b0, proc_addr}, 32'h7);

    // Redirect mid-hit: odd target is forced even.
    applyStimulus(1'b1, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 32'h0000_0101);
    checkOutput("br_addr", {1'b0, proc_addr}, 32'h80);
    checkOutput("br_valid", {31'h0, ifid_valid}, 32'h0);
    hit(1'b1, 32'h3333_4444);
    checkOutput("br_ifid_pc", ifid_pc, 32'h100);

    // Miss with two redirects parked; newest target wins after release.
    hold_addr = proc_addr;
    hold_scnt = perf_stall_cnt;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, $urandom, 1'b1, 1'b0, (c == 2) || (c == 4),
                    (c == 2) ? 32'h200 : 32'h300);
      checkOutput("miss_addr_frozen", {1'b0, proc_addr}, {1'b0, hold_addr});
      checkOutput("miss_valid", {31'h0, ifid_valid}, 32'h0);
    end
    checkOutput("miss_stall_delta", perf_stall_cnt - hold_scnt, PERF ? 32'd5 : 32'd0);
    hit(1'b1, $urandom);
    checkOutput("release_addr", {1'b0, proc_addr}, 32'h180);
    checkOutput("release_valid", {31'h0, ifid_valid}, 32'h0);

    // ID hazard holds everything; a redirect overrides it.
    hit(1'b0, 32'hABCD_EF01);
    hold_pc = ifid_pc; hold_instr = ifid_instr; hold_addr = proc_addr;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("ids_pc", ifid_pc, hold_pc);
      checkOutput("ids_instr", ifid_instr, hold_instr);
      checkOutput("ids_addr", {1'b0, proc_addr}, {1'b0, hold_addr});
    end
    applyStimulus(1'b1, $urandom, 1'b0, 1'b1, 1'b1, 32'h40);
    checkOutput("ids_br_addr", {1'b0, proc_addr}, 32'h20);

    // Wrap-around at the top of the address space.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    hit(1'b1, 32'h1300_0000);
    checkOutput("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_inc", ifid_pc_inc, 32'h0);
    checkOutput("wrap_addr", {1'b0, proc_addr}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(1, 0) == 1, $urandom,
                    $urandom_range(3, 0) == 0, $urandom_range(6, 0) == 0,
                    $urandom_range(9, 0) == 0, $urandom);
    end

    // Asynchronous reset in the middle of a miss.
    applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 32'h500);
    #1;
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(1, 0) == 1, $urandom,
                    $urandom_range(3, 0) == 0, $urandom_range(6, 0) == 0,
                    $urandom_range(9, 0) == 0, $urandom);
    end

    @(posedge clk);
    #3;
    checkOutput("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
